// File: rtl/fb_switch_sequencer_if.sv
// fb_switch_sequencer_if: frame-start/busy/ack handshakes and status outputs of the bank-switch sequencer
interface fb_switch_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             wr_frame_start;
  logic             rd_frame_start;
  logic             wr_busy;
  logic             rd_busy;
  logic             wr_sw_ack;
  logic             rd_sw_ack;
  logic             wr_sw;
  logic             rd_sw;
  logic             wr_frame_go;
  logic             rd_frame_go;
  logic [CNT_W-1:0] frame_drop_cnt;
  logic [CNT_W-1:0] frame_repeat_cnt;
  logic             timeout_err;
  modport master (
    input  wr_frame_start, rd_frame_start, wr_busy, rd_busy, wr_sw_ack, rd_sw_ack,
    output wr_sw, rd_sw, wr_frame_go, rd_frame_go, frame_drop_cnt, frame_repeat_cnt, timeout_err
  );
  modport slave (
    output wr_frame_start, rd_frame_start, wr_busy, rd_busy, wr_sw_ack, rd_sw_ack,
    input  wr_sw, rd_sw, wr_frame_go, rd_frame_go, frame_drop_cnt, frame_repeat_cnt, timeout_err
  );
endinterface

// File: rtl/fb_switch_sequencer.sv
// fb_switch_sequencer: per-side frame FSMs issuing bank-switch requests and DMA go pulses; FB_SEQ_STATUS_EN adds status counters/error
module fb_switch_sequencer #(
  parameter int FB_NUM      = 2,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic                   ddr_clk,
  input logic                   rst,
  fb_switch_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, DRAIN, REQ, GO} state_t;
  localparam bit PAIRED = FB_NUM == 2;
  localparam int TW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
  logic [1:0]    start, busy, ack, tmo, bad_start, sw_q, go_q;
  state_t        state_q [2];
  state_t        state_d [2];
  logic [TW-1:0] timer_q [2];
  logic [TW-1:0] timer_d [2];
  assign start = {bus.rd_frame_start, bus.wr_frame_start};
  assign busy  = {bus.rd_busy, bus.wr_busy};
  assign ack   = {bus.rd_sw_ack, bus.wr_sw_ack};
  // next state per side (0 = write, 1 = read); ack is checked before timeout so it wins a tie
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      state_d[s]   = state_q[s];
      timer_d[s]   = timer_q[s];
      tmo[s]       = 1'b0;
      bad_start[s] = 1'b0;
      case (state_q[s])
        IDLE: state_d[s] = start[s] ? DRAIN : IDLE;
        DRAIN: begin
          timer_d[s]   = '0;
          bad_start[s] = start[s];
          state_d[s]   = busy[s] ? DRAIN : REQ;
        end
        REQ: begin
          bad_start[s] = start[s];
          timer_d[s]   = ack[s] ? timer_q[s] : timer_q[s] + TW'(1);
          tmo[s]       = !ack[s] && ACK_TIMEOUT != 0 && timer_q[s] == TW'(ACK_TIMEOUT - 1);
          state_d[s]   = (ack[s] || tmo[s]) ? GO : REQ;
        end
        GO: state_d[s] = start[s] ? DRAIN : IDLE;
      endcase
    end
  end
  // state, timers, and request/go outputs registered from the next state so sw is low in GO
  always_ff @(posedge ddr_clk or posedge rst) begin
    if (rst) begin
      state_q <= '{IDLE, IDLE};
      timer_q <= '{default: '0};
      sw_q    <= '0;
      go_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      go_q    <= {state_d[1] == GO, state_d[0] == GO};
      sw_q    <= PAIRED ? {2{state_d[0] == REQ && state_d[1] == REQ}} : {state_d[1] == REQ, state_d[0] == REQ};
    end
  end
  assign bus.wr_sw       = sw_q[0];
  assign bus.rd_sw       = sw_q[1];
  assign bus.wr_frame_go = go_q[0];
  assign bus.rd_frame_go = go_q[1];
`ifdef FB_SEQ_STATUS_EN
  logic [CNT_W-1:0] drop_q, repeat_q;
  logic             err_q;
  // saturating timeout counters; error is sticky until reset
  always_ff @(posedge ddr_clk or posedge rst) begin
    if (rst) begin
      drop_q   <= '0;
      repeat_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (tmo[0] && !(&drop_q)) drop_q <= drop_q + CNT_W'(1);
      if (tmo[1] && !(&repeat_q)) repeat_q <= repeat_q + CNT_W'(1);
      if (|bad_start || (!PAIRED && |tmo)) err_q <= 1'b1;
    end
  end
  assign bus.frame_drop_cnt   = drop_q;
  assign bus.frame_repeat_cnt = repeat_q;
  assign bus.timeout_err      = err_q;
`else
  logic unused_status;
  assign unused_status        = ^{tmo, bad_start};
  assign bus.frame_drop_cnt   = '0;
  assign bus.frame_repeat_cnt = '0;
  assign bus.timeout_err      = 1'b0;
`endif
endmodule
